wishbone_master_seq: RTL and testbench

Synthesizable, parametrised Wishbone classic master for the SD host controller register/data path, replacing free-running stimulus generators with a command-driven transaction engine. It accepts a command (direction, start address, beat count), runs single or incrementing-burst cycles with a full CYC/STB/ACK handshake, and streams write data in and read data out. It adds bus-error handling and an ack timeout.

---
 rtl/wishbone_master_seq_if.sv | 24 ++
 rtl/wishbone_master_seq.sv | 141 ++++++++++++++
 tb/tb_wishbone_master_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_master_seq_if.sv
// rtl/wishbone_master_seq_if.sv - Wishbone classic bus bundle between wishbone_master_seq and its slave
interface wishbone_master_seq_if #(
    parameter int DATA_W = 64,
    parameter int ADR_W  = 8
);
    logic              cyc_o;
    logic              stb_o;
    logic              we_o;
    logic [ADR_W-1:0]  adr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              ack_i;
    logic              err_i;
    logic [DATA_W-1:0] wb_data_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, wb_data_o,
        input  ack_i, err_i, wb_data_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, wb_data_o,
        output ack_i, err_i, wb_data_i
    );
endinterface

// File: rtl/wishbone_master_seq.sv
// rtl/wishbone_master_seq.sv - command-driven Wishbone classic master with bursts, bus error and ack timeout
module wishbone_master_seq #(
    parameter int DATA_W   = 64,
    parameter int ADR_W    = 8,
    parameter int LEN_W    = 4,
    parameter int ADR_STEP = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADR_W-1:0]     cmd_adr,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 done,
    output logic                 err,
    wishbone_master_seq_if.master wb
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_REQ,
        S_GAP,
        S_DONE,
        S_ABORT
    } state_t;

    localparam int                TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit                TMO_EN   = (TIMEOUT != 0);
    localparam logic [ADR_W-1:0]  ADR_INC  = ADR_W'(ADR_STEP);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            adr_q      <= '0;
            wdat_q     <= '0;
            beat_q     <= '0;
            tmo_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            beat_q     <= beat_d;
            tmo_q      <= tmo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // beat_q counts remaining beats minus one, so zero marks the last beat
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        beat_d     = beat_q;
        tmo_d      = '0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    beat_d  = cmd_len;
                    state_d = cmd_we ? S_WDATA : S_REQ;
                end
            end
            S_WDATA: begin
                if (wr_valid) begin
                    wdat_d  = wr_data;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // a bus error outranks an ack presented in the same cycle
                if (wb.err_i) begin
                    state_d = S_ABORT;
                end else if (wb.ack_i) begin
                    if (!we_q) begin
                        rd_data_d  = wb.wb_data_i;
                        rd_valid_d = 1'b1;
                    end
                    if (beat_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        adr_d   = adr_q + ADR_INC;
                        beat_d  = beat_q - LEN_W'(1);
                    end
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    state_d = S_ABORT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                state_d = we_q ? S_WDATA : S_REQ;
            end
            S_DONE, S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign wr_ready     = (state_q == S_WDATA);
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign done         = (state_q == S_DONE) || (state_q == S_ABORT);
    assign err          = (state_q == S_ABORT);

    assign wb.cyc_o     = (state_q == S_WDATA) || (state_q == S_REQ) || (state_q == S_GAP);
    assign wb.stb_o     = (state_q == S_REQ);
    assign wb.we_o      = we_q;
    assign wb.adr_o     = adr_q;
    assign wb.wb_data_o = wdat_q;
endmodule

// File: tb/tb_wishbone_master_seq.sv
// tb/tb_wishbone_master_seq.sv - scoreboard bench for wishbone_master_seq with a behavioural slave and reference memory
module tb_wishbone_master_seq;
    localparam int DATA_W   = 64;
    localparam int ADR_W    = 8;
    localparam int LEN_W    = 4;
    localparam int ADR_STEP = 1;
    localparam int TIMEOUT  = 4;

    localparam int K_ACK     = 0;
    localparam int K_ERR     = 1;
    localparam int K_ERR_ACK = 2;
    localparam int K_NEVER   = 3;

    typedef struct {
        int                waits;
        int                kind;
        int                exp_run;
        logic [ADR_W-1:0]  adr;
        logic              we;
        logic [DATA_W-1:0] dat;
    } plan_t;

    typedef struct {
        logic err;
        int   lat;
    } done_t;

    logic              clock;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADR_W-1:0]  cmd_adr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;

    wishbone_master_seq_if #(.DATA_W(DATA_W), .ADR_W(ADR_W)) wb ();

    wishbone_master_seq #(
        .DATA_W(DATA_W), .ADR_W(ADR_W), .LEN_W(LEN_W), .ADR_STEP(ADR_STEP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .wb(wb)
    );

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    int acc_cyc = 0;

    plan_t             plan_q[$];
    done_t             exp_done[$];
    logic [DATA_W-1:0] exp_rd[$];
    logic [DATA_W-1:0] wr_q[$];
    int                wr_hold = 0;

    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] ref_mem [256];

    plan_t cur;
    plan_t rp;
    done_t dd;
    bit    busy, gap_chk, took, rst_prev, take_prev, done_prev, wait_ok;
    int    run;
    bit    r_we;
    int    r_len, r_fb, r_fk;

    function automatic void check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Slave: answers each STB phase from the head of plan_q and checks the bus against it
    initial begin
        busy = 0; gap_chk = 0; run = 0;
        wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.wb_data_i = '0;
        forever begin
            @(negedge clock);
            wb.ack_i = 1'b0;
            wb.err_i = 1'b0;
            wb.wb_data_i = {$urandom, $urandom};
            if (gap_chk) begin
                check("stb_gap", wb.stb_o, 0);
                gap_chk = 0;
            end
            if (wb.stb_o && !busy) begin
                check("stb_planned", plan_q.size() > 0, 1);
                if (plan_q.size() > 0) begin
                    cur = plan_q.pop_front();
                    busy = 1;
                    run = 0;
                end
            end
            if (wb.stb_o && busy) begin
                run++;
                if (cur.kind != K_NEVER && run == cur.waits + 1) begin
                    check("adr_o", wb.adr_o, cur.adr);
                    check("we_o", wb.we_o, cur.we);
                    if (cur.we) check("wb_data_o", wb.wb_data_o, cur.dat);
                    else wb.wb_data_i = mem[wb.adr_o];
                    if (cur.kind == K_ACK) begin
                        wb.ack_i = 1'b1;
                        if (cur.we) mem[wb.adr_o] = wb.wb_data_o;
                    end else begin
                        wb.err_i = 1'b1;
                        wb.ack_i = (cur.kind == K_ERR_ACK);
                    end
                    busy = 0;
                    gap_chk = 1;
                end
            end else if (busy) begin
                if (cur.exp_run > 0) check("stb_timeout_len", run, cur.exp_run);
                busy = 0;
            end
        end
    end

    // Write-data source: presents the head of wr_q unless a hold is pending
    initial begin
        wr_valid = 1'b0;
        wr_data = '0;
        forever begin
            @(negedge clock);
            took = wr_valid && wr_ready;
            @(posedge clock);
            #1;
            if (took && wr_q.size() > 0) void'(wr_q.pop_front());
            if (wr_hold > 0) begin
                wr_hold--;
                wr_valid = 1'b0;
            end else if (wr_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data = wr_q[0];
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    // Output monitor
    initial begin
        rst_prev = 0; take_prev = 0; done_prev = 0;
        forever begin
            @(negedge clock);
            cyc_n++;
            if (rst_prev)
                check("reset_state",
                      {wb.cyc_o, wb.stb_o, wb.we_o, cmd_ready, wr_ready, rd_valid, done, err, wb.adr_o},
                      {8'b0001_0000, 8'h00});
            if (cmd_valid && cmd_ready) acc_cyc = cyc_n;
            if (rd_valid) begin
                check("rd_valid_expected", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (done) begin
                check("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    dd = exp_done.pop_front();
                    check("done_err", err, dd.err);
                    check("rd_beats_outstanding", exp_rd.size(), 0);
                    if (dd.lat >= 0) check("latency", cyc_n - acc_cyc, dd.lat);
                end
            end else begin
                check("err_without_done", err, 0);
            end
            if (wr_ready) check("wdata_bus_state", {wb.cyc_o, wb.stb_o}, 2'b10);
            if (take_prev) check("stb_after_wdata", wb.stb_o, 1);
            if (done_prev) check("ready_after_done", cmd_ready, 1);
            take_prev = wr_valid && wr_ready;
            done_prev = done;
            rst_prev = reset;
        end
    end

    task automatic recover();
        reset = 1'b1;
        plan_q.delete();
        exp_done.delete();
        exp_rd.delete();
        wr_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic issue(input bit we, input logic [ADR_W-1:0] adr, input int len);
        bit ok;
        ok = 0;
        @(negedge clock);
        @(posedge clock);
        #1;
        cmd_we = we;
        cmd_adr = adr;
        cmd_len = LEN_W'(len);
        cmd_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        check("cmd_accepted", ok, 1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            #1;
            if (exp_done.size() == 0 && plan_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("cmd_completed", ok, 1);
        if (!ok) recover();
    endtask

    // Reference model: beat addresses, slave responses, memory effect and completion cycle of one command
    task automatic run_cmd(input bit we, input logic [ADR_W-1:0] adr, input int len, input int minw, input int maxw,
                           input int fault_beat, input int fault_kind, input bit chk_lat, input bit seq_data,
                           input int hold);
        int    tot;
        int    last;
        bit    faulted;
        plan_t p;
        done_t d;
        tot = 0; last = 0; faulted = 0;
        for (int i = 0; i <= len; i++) begin
            p.adr = adr + ADR_W'(i * ADR_STEP);
            p.we = we;
            p.waits = $urandom_range(maxw, minw);
            p.exp_run = 0;
            p.kind = (i == fault_beat) ? fault_kind : K_ACK;
            p.dat = seq_data ? DATA_W'(i + 1) : {$urandom, $urandom};
            if (we) wr_q.push_back(p.dat);
            if (p.kind == K_NEVER) begin
                p.exp_run = TIMEOUT;
                tot += int'(we) + TIMEOUT;
            end else begin
                tot += int'(we) + p.waits + 1;
            end
            if (p.kind == K_ACK) begin
                if (we) ref_mem[p.adr] = p.dat;
                else exp_rd.push_back(ref_mem[p.adr]);
            end
            plan_q.push_back(p);
            last = i;
            if (p.kind != K_ACK) begin
                faulted = 1;
                break;
            end
        end
        d.err = faulted;
        d.lat = chk_lat ? tot + last + 1 : -1;
        exp_done.push_back(d);
        wr_hold = hold;
        issue(we, adr, len);
        wait_done();
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_adr = '0;
        cmd_len = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        mem[8'h10] = 64'hDEAD_BEEF;
        ref_mem[8'h10] = 64'hDEAD_BEEF;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        run_cmd(1'b0, 8'h10, 0, 0, 0, -1, K_ACK, 1'b1, 1'b0, 0);
        run_cmd(1'b1, 8'hFE, 3, 2, 2, -1, K_ACK, 1'b1, 1'b1, 0);
        run_cmd(1'b0, 8'h20, 2, 0, 1, 1, K_ERR_ACK, 1'b1, 1'b0, 0);
        run_cmd(1'b0, 8'h30, 0, 0, 0, 0, K_NEVER, 1'b1, 1'b0, 0);
        run_cmd(1'b1, 8'h50, 1, 0, 1, -1, K_ACK, 1'b0, 1'b0, 11);

        // reset while the second beat of a read burst is waiting for its ack
        rp.waits = 0; rp.kind = K_ACK; rp.exp_run = 0; rp.adr = 8'h40; rp.we = 1'b0; rp.dat = '0;
        plan_q.push_back(rp);
        exp_rd.push_back(ref_mem[8'h40]);
        rp.kind = K_NEVER; rp.adr = 8'h41;
        plan_q.push_back(rp);
        issue(1'b0, 8'h40, 3);
        wait_ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            #1;
            if (plan_q.size() == 0 && wb.stb_o) begin
                wait_ok = 1;
                break;
            end
        end
        check("rst_reached_beat2", wait_ok, 1);
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        #1;
        check("rst_plans_flushed", plan_q.size(), 0);
        check("rst_rd_flushed", exp_rd.size(), 0);
        run_cmd(1'b1, 8'h60, 2, 0, 2, -1, K_ACK, 1'b1, 1'b0, 0);
        run_cmd(1'b0, 8'h60, 2, 0, 2, -1, K_ACK, 1'b1, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            r_we = 1'($urandom_range(1, 0));
            r_len = $urandom_range(15, 0);
            r_fb = -1;
            r_fk = K_ACK;
            if ($urandom_range(4, 0) == 0) begin
                r_fb = $urandom_range(r_len, 0);
                r_fk = $urandom_range(3, 1);
            end
            run_cmd(r_we, ADR_W'($urandom), r_len, 0, 2, r_fb, r_fk, 1'b1, 1'b0, 0);
        end

        repeat (3) @(negedge clock);
        check("final_plans_empty", plan_q.size(), 0);
        check("final_rd_empty", exp_rd.size(), 0);
        check("final_wr_empty", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
